// File: rtl/logic_unit_seq_if.sv
// Request/response bundle for the chunked bitwise logic unit.
// The master drives operands and accepts results; the slave is the unit itself.
interface logic_unit_seq_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, zero, negative
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, zero, negative
    );
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: latches A/B/op on accept, then computes
// CHUNK bits per cycle into the result register, and presents the result
// with zero/negative flags until the consumer takes it.
module logic_unit_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input logic           clk,
    input logic           rst_n,
    logic_unit_seq_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ZERO = 3'b000,
        OP_OR   = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_NOR  = 3'b100,
        OP_NAND = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    op_t              op_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nxt;
    logic             nz_acc;
    logic             zero_r;
    logic             neg_r;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] f_sl;
    logic             accept;
    logic             last;

    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_r;
    assign bus.zero      = zero_r;
    assign bus.negative  = neg_r;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == LAST);

    // Select the operand slices addressed by the chunk counter
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                a_sl = a_r[i*CHUNK +: CHUNK];
                b_sl = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

    // Apply the latched operation to the current slice
    always_comb begin
        f_sl = '0;
        case (op_r)
            OP_ZERO: f_sl = '0;
            OP_OR:   f_sl = a_sl | b_sl;
            OP_AND:  f_sl = a_sl & b_sl;
            OP_XOR:  f_sl = a_sl ^ b_sl;
            OP_NOR:  f_sl = ~(a_sl | b_sl);
            OP_NAND: f_sl = ~(a_sl & b_sl);
            OP_XNOR: f_sl = ~(a_sl ^ b_sl);
            OP_PASS: f_sl = a_sl;
            default: f_sl = '0;
        endcase
    end

    // Merge the computed slice into the running result
    always_comb begin
        res_nxt = res_r;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                res_nxt[i*CHUNK +: CHUNK] = f_sl;
            end
        end
    end

    // Next-state decode: accept in IDLE, step through chunks, hold until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, chunked result build-up and flag generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= OP_ZERO;
            cnt    <= '0;
            res_r  <= '0;
            nz_acc <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r    <= bus.A;
                        b_r    <= bus.B;
                        op_r   <= op_t'(bus.op);
                        res_r  <= '0;
                        cnt    <= '0;
                        nz_acc <= 1'b0;
                    end
                end
                RUN: begin
                    res_r  <= res_nxt;
                    nz_acc <= nz_acc | (|f_sl);
                    // Counter parks on the last chunk instead of wrapping
                    if (last) begin
                        zero_r <= !(nz_acc | (|f_sl));
                        neg_r  <= res_nxt[WIDTH-1];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq in three configurations:
// 64/8 (directed), 32/32 and 16/4 (random vs reference model).
module tb_logic_unit_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_unit_seq_if #(.WIDTH(64)) bus0 ();
    logic_unit_seq_if #(.WIDTH(32)) bus1 ();
    logic_unit_seq_if #(.WIDTH(16)) bus2 ();

    logic_unit_seq #(.WIDTH(64), .CHUNK(8))  u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    logic_unit_seq #(.WIDTH(32), .CHUNK(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    logic_unit_seq #(.WIDTH(16), .CHUNK(4))  u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic        n;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Independent reference: whole-word op, masked to the configured width
    function automatic exp_t model(input logic [2:0] o, input logic [63:0] a,
                                   input logic [63:0] b, input int unsigned w);
        exp_t        e;
        logic [63:0] r;
        logic [63:0] mask;
        case (o)
            3'd0: r = 64'd0;
            3'd1: r = a | b;
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: r = ~(a | b);
            3'd5: r = ~(a & b);
            3'd6: r = ~(a ^ b);
            default: r = a;
        endcase
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r     = r & mask;
        e.res = r;
        e.z   = (r == 64'd0);
        e.n   = r[w-1];
        return e;
    endfunction

    task automatic mon_step(input string tag, input int lat, input int acc, input logic prev,
                            input logic ov, input logic ordy, input logic irdy_v,
                            input logic [63:0] res, input logic z, input logic n,
                            input int qsz, input exp_t f, output logic pop);
        pop = 1'b0;
        if (ov) begin
            if (!prev) chk({tag, " latency"}, 64'(cyc - acc), 64'(lat));
            if (qsz == 0) begin
                chk({tag, " out_valid with nothing pending"}, 64'(ov), 64'd0);
            end else begin
                chk({tag, " result"}, res, f.res);
                chk({tag, " zero"}, 64'(z), 64'(f.z));
                chk({tag, " negative"}, 64'(n), 64'(f.n));
                chk({tag, " in_ready in DONE"}, 64'(irdy_v), 64'd0);
                pop = ordy;
            end
        end
    endtask

    logic prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;
    int   acc0 = 0, acc1 = 0, acc2 = 0;

    always @(negedge clk) begin
        exp_t f;
        logic pop;
        if (!rst_n) prev0 = 1'b0;
        else begin
            if (bus0.in_valid && bus0.in_ready) acc0 = cyc + 1;
            f = (q0.size() != 0) ? q0[0] : '0;
            mon_step("u0", 8, acc0, prev0, bus0.out_valid, bus0.out_ready, bus0.in_ready,
                     bus0.result, bus0.zero, bus0.negative, q0.size(), f, pop);
            if (pop) void'(q0.pop_front());
            prev0 = bus0.out_valid;
        end
    end

    always @(negedge clk) begin
        exp_t f;
        logic pop;
        if (!rst_n) prev1 = 1'b0;
        else begin
            if (bus1.in_valid && bus1.in_ready) acc1 = cyc + 1;
            f = (q1.size() != 0) ? q1[0] : '0;
            mon_step("u1", 1, acc1, prev1, bus1.out_valid, bus1.out_ready, bus1.in_ready,
                     64'(bus1.result), bus1.zero, bus1.negative, q1.size(), f, pop);
            if (pop) void'(q1.pop_front());
            prev1 = bus1.out_valid;
        end
    end

    always @(negedge clk) begin
        exp_t f;
        logic pop;
        if (!rst_n) prev2 = 1'b0;
        else begin
            if (bus2.in_valid && bus2.in_ready) acc2 = cyc + 1;
            f = (q2.size() != 0) ? q2[0] : '0;
            mon_step("u2", 4, acc2, prev2, bus2.out_valid, bus2.out_ready, bus2.in_ready,
                     64'(bus2.result), bus2.zero, bus2.negative, q2.size(), f, pop);
            if (pop) void'(q2.pop_front());
            prev2 = bus2.out_valid;
        end
    end

    task automatic drive(input int unsigned u, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] o);
        case (u)
            0: begin bus0.in_valid = v; bus0.A = a;        bus0.B = b;        bus0.op = o; end
            1: begin bus1.in_valid = v; bus1.A = a[31:0];  bus1.B = b[31:0];  bus1.op = o; end
            default: begin bus2.in_valid = v; bus2.A = a[15:0]; bus2.B = b[15:0]; bus2.op = o; end
        endcase
    endtask

    function automatic logic irdy(input int unsigned u);
        case (u)
            0:       return bus0.in_ready;
            1:       return bus1.in_ready;
            default: return bus2.in_ready;
        endcase
    endfunction

    // Present a request, wait (bounded) for acceptance, and log its expectation
    task automatic issue(input int unsigned u, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] o, input exp_t e);
        bit ok = 1'b0;
        drive(u, 1'b1, a, b, o);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (irdy(u)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("issue wait for in_ready");
        else begin
            case (u)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
        drive(u, 1'b0, a, b, o);
    endtask

    task automatic vec0(input logic [63:0] a, input logic [63:0] b, input logic [2:0] o,
                        input logic [63:0] r, input logic z, input logic n);
        exp_t e;
        e.res = r;
        e.z   = z;
        e.n   = n;
        issue(0, a, b, o, e);
    endtask

    task automatic drain();
        int k = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) bound_fail("drain scoreboard");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        drive(0, 1'b0, '0, '0, 3'd0);
        drive(1, 1'b0, '0, '0, 3'd0);
        drive(2, 1'b0, '0, '0, 3'd0);
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        bus2.out_ready = 1'b1;

        // Reset and ready
        repeat (3) begin
            @(negedge clk);
            chk("reset result", bus0.result, 64'd0);
            chk("reset out_valid", 64'(bus0.out_valid), 64'd0);
            chk("reset in_ready", 64'(bus0.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("u0 in_ready after release", 64'(bus0.in_ready), 64'd1);
        chk("u1 in_ready after release", 64'(bus1.in_ready), 64'd1);
        chk("u2 in_ready after release", 64'(bus2.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors on the 64/8 unit
        vec0(64'h00FF_0000_0000_1234, 64'h8000_0000_0000_4321, 3'b001, 64'h80FF_0000_0000_5335, 1'b0, 1'b1);
        vec0(64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF, 3'b011, 64'h0, 1'b1, 1'b0);
        vec0(64'h0, 64'h0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        vec0(64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 3'b000, 64'h0, 1'b1, 1'b0);
        vec0(64'hF0F0_F0F0_1234_5678, 64'hFF00_FF00_00FF_FFFF, 3'b010, 64'hF000_F000_0034_5678, 1'b0, 1'b1);
        vec0(64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFE, 3'b101, 64'h8000_0000_0000_0001, 1'b0, 1'b1);
        vec0(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        vec0(64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'h0000_0000_0000_0080, 1'b0, 1'b0);
        vec0(64'h0100_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'h0100_0000_0000_0000, 1'b0, 1'b0);
        drain();

        // Back-pressure with new requests attempted while DONE
        bus0.out_ready = 1'b0;
        vec0(64'h0, 64'h0000_0000_0000_0001, 3'b001, 64'h1, 1'b0, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus0.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("wait for out_valid under back-pressure");
        repeat (5) begin
            @(posedge clk);
            #1;
            drive(0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'b011);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0, '0, 3'd0);
        bus0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("in_ready after handshake", 64'(bus0.in_ready), 64'd1);
        chk("out_valid after handshake", 64'(bus0.out_valid), 64'd0);
        chk("result held after handshake", bus0.result, 64'h1);
        @(posedge clk);
        #1;
        vec0(64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b011, 64'hF0F0_0F0F_F0F0_0F0F, 1'b0, 1'b1);
        drain();

        // Reset asserted during the 4th RUN cycle
        vec0(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 3'b010, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        q0.delete();
        chk("mid-run reset out_valid", 64'(bus0.out_valid), 64'd0);
        chk("mid-run reset result", bus0.result, 64'd0);
        chk("mid-run reset in_ready", 64'(bus0.in_ready), 64'd0);
        chk("mid-run reset zero", 64'(bus0.zero), 64'd0);
        chk("mid-run reset negative", 64'(bus0.negative), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec0(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 3'b010, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        drain();

        // Random sweep on the 32/32 and 16/4 units
        for (int unsigned u = 1; u <= 2; u++) begin
            for (int t = 0; t < 200; t++) begin
                logic [63:0] a;
                logic [63:0] b;
                logic [2:0]  o;
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                o = 3'($urandom_range(0, 7));
                if (u == 1) begin
                    a = a & 64'hFFFF_FFFF;
                    b = b & 64'hFFFF_FFFF;
                end else begin
                    a = a & 64'hFFFF;
                    b = b & 64'hFFFF;
                end
                issue(u, a, b, o, model(o, a, b, (u == 1) ? 32 : 16));
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
- Parametrised multi-cycle bitwise logic unit for the ALU; successor to the 1-bit gated OR slice.
- Generalises it to WIDTH-bit operands and eight selectable ops; op 000 forces a zero result, as sel=0 does in the single-bit slice.
- Processes CHUNK bits per cycle under a valid/ready handshake and produces zero and negative flags for the flag register.

Parameters:
WIDTH, 64, operand and result width in bits; must be an integer multiple of CHUNK.
CHUNK, 8, bits computed per RUN cycle; NCHUNK = WIDTH/CHUNK, must be at least 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  unit can accept a request.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
op  input  3  000 zero, 001 OR, 010 AND, 011 XOR, 100 NOR, 101 NAND, 110 XNOR, 111 pass A.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  bitwise result.
zero  output  1  result == 0.
negative  output  1  result[WIDTH-1].

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n.
- While rst_n is low: state=IDLE, counter=0, result=0, zero=0, negative=0, out_valid=0, in_ready=0.
- in_ready = (state==IDLE) && rst_n. It is 1 from the first cycle after reset release.
- States:
  - IDLE:
    - On in_valid && in_ready at a clock edge, latch A, B and op into internal registers.
    - Clear result to 0, set counter=0, clear the zero accumulator, go to RUN.
    - Operand inputs are ignored at all other times.
  - RUN:
    - Each edge writes result[counter*CHUNK +: CHUNK] = f(op, A_r, B_r) over that slice.
    - On the same edge, OR that slice into the nonzero accumulator and increment counter.
    - On the edge where counter==NCHUNK-1:
      - go to DONE;
      - set out_valid=1;
      - set zero = !(accumulator | final slice);
      - set negative = MSB of the final result.
  - DONE:
    - out_valid=1; result and flags are held stable.
    - On out_ready high at an edge: out_valid=0, go to IDLE.
    - result and flags retain their values after the handshake until the next accept.
- Latency:
  - out_valid rises exactly NCHUNK edges after the accepting edge.
  - NCHUNK=1 gives one cycle.
  - Minimum issue interval is NCHUNK+2 cycles (accept, RUN×NCHUNK, DONE handshake, then IDLE).
- No overlap: a new request cannot be accepted in the DONE cycle, even if out_ready is high.
- Back-pressure: out_ready low holds DONE indefinitely, with no change to result or flags.
- A_r, B_r and op_r do not change during RUN, so input changes after accept have no effect.
- Op 000 produces all-zero result, zero=1, negative=0.
- Op 111 copies A; B is ignored.
- Reset asserted mid-RUN or in DONE:
  - immediately forces the reset values;
  - no partial result is presented;
  - the first request after release is processed normally.
- Counter width is clog2(NCHUNK), minimum 1 bit. The counter never exceeds NCHUNK-1.
- Gate delays are not modelled; RTL is synchronous.

Test Plan:
1. Reset and ready:
   - Stimulus: hold rst_n=0 for 3 cycles, then release.
   - Required: result=0, out_valid=0, in_ready=0 during reset; in_ready=1 on the first cycle after release.
2. OR, WIDTH=64, CHUNK=8:
   - Stimulus: A=0x00FF_0000_0000_1234, B=0x8000_0000_0000_4321, op=001.
   - Required: out_valid exactly 8 edges after accept; result=0x80FF_0000_0000_5335, zero=0, negative=1.
3. Zero flag, all ops:
   - XOR with A=B=0xDEAD_BEEF_DEAD_BEEF: result=0, zero=1, negative=0.
   - NOR with A=B=0: result=0xFFFF_FFFF_FFFF_FFFF, negative=1.
   - Op 000 with arbitrary operands: result=0, zero=1.
4. Back-pressure and no overlap:
   - Stimulus: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and operands changing.
   - Required: result and flags stable and in_ready=0 throughout. After out_ready=1, one cycle returns to IDLE; the next request is accepted and computes correctly.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 during the 4th RUN cycle.
   - Required: outputs reset asynchronously; out_valid never pulses. A request after release returns the correct AND result with latency 8.
6. Parameter sweep:
   - Configurations: WIDTH=32/CHUNK=32 (latency 1) and WIDTH=16/CHUNK=4 (latency 4).
   - Stimulus: random A, B and op, 200 transactions each.
   - Required: match a reference model bit-exactly.
